// File: rtl/cluster_count_pipe_pkg.sv
// Shared cluster package: leaf width, clog2 and the derived count width / pipeline depth.
// The cluster finder imports the same helpers so both blocks agree on CNT_W and latency.
package cluster_count_pipe_pkg;

    localparam int LEAF_W     = 6;
    localparam int LEAF_CNT_W = 3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int nvpfs);
        return clog2(nvpfs + 1);
    endfunction

    function automatic int tree_levels(input int nvpfs);
        return clog2(nvpfs / LEAF_W);
    endfunction

    // Two input stages, one leaf stage, the adder tree and the output register.
    function automatic int latency(input int nvpfs);
        return 4 + tree_levels(nvpfs);
    endfunction

endpackage

// File: rtl/cluster_count_pipe_if.sv
// Bus bundle for the cluster popcount pipeline: flag samples in, counts and statistics out.
// Handshake: valid_i qualifies vpfs_i in that cycle and valid_o qualifies cnt_o/overflow_o; there is no ready, the pipe accepts every cycle.
interface cluster_count_pipe_if #(
    parameter int NVPFS  = 1536,
    parameter int STAT_W = 16,
    parameter int CNT_W  = cluster_count_pipe_pkg::cnt_w(NVPFS)
);
    logic [NVPFS-1:0]  vpfs_i;
    logic              valid_i;
    logic [CNT_W-1:0]  thresh_i;
    logic              clr_i;
    logic [CNT_W-1:0]  cnt_o;
    logic              valid_o;
    logic              overflow_o;
    logic [STAT_W-1:0] ovf_events_o;
    logic [CNT_W-1:0]  peak_o;

    modport master (
        output vpfs_i, valid_i, thresh_i, clr_i,
        input  cnt_o, valid_o, overflow_o, ovf_events_o, peak_o
    );

    modport slave (
        input  vpfs_i, valid_i, thresh_i, clr_i,
        output cnt_o, valid_o, overflow_o, ovf_events_o, peak_o
    );
endinterface

// File: rtl/cluster_count_pipe_popcount6.sv
// Leaf popcount: number of set bits in a 6-flag group, purely combinational.
module popcount6 (
    input  logic [5:0] i_bits,
    output logic [2:0] o_cnt
);
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < 6; i++) begin
            o_cnt = o_cnt + {2'b00, i_bits[i]};
        end
    end
endmodule

// File: rtl/cluster_count_pipe.sv
// Pipelined popcount of the cluster valid-pattern flags with threshold overflow,
// a saturating overflow-event counter and a running peak count.
module cluster_count_pipe #(
    parameter int NVPFS  = 1536,
    parameter int LEAF_W = cluster_count_pipe_pkg::LEAF_W,
    parameter int STAT_W = 16
) (
    input  logic                 clock4x,
    input  logic                 reset_n,
    cluster_count_pipe_if.slave  bus
);
    import cluster_count_pipe_pkg::*;

    localparam int CNT_W = cnt_w(NVPFS);
    localparam int NL    = NVPFS / LEAF_W;
    localparam int LVLS  = tree_levels(NVPFS);
    localparam int L     = latency(NVPFS);

    // Data stages carry no reset; the valid chain alone decides what reaches cnt_o.
    logic [NVPFS-1:0] r_s0_vpfs;
    logic [NVPFS-1:0] r_s1_vpfs;
    logic [L-1:0]     r_vld;

    always_ff @(posedge clock4x) begin
        r_s0_vpfs <= bus.vpfs_i;
        r_s1_vpfs <= r_s0_vpfs;
    end

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[L-2:0], bus.valid_i};
        end
    end

    logic [LEAF_CNT_W-1:0] w_leaf [NL];

    for (genvar g = 0; g < NL; g++) begin : g_pc
        popcount6 u_popcount6 (
            .i_bits (r_s1_vpfs[g*LEAF_W +: LEAF_W]),
            .o_cnt  (w_leaf[g])
        );
    end

    // Level 0 holds the registered leaves; each later level halves the node count and grows one bit.
    for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
        localparam int W = (LEAF_CNT_W + k < CNT_W) ? LEAF_CNT_W + k : CNT_W;
        localparam int N = NL >> k;
        logic [W-1:0] r_sum [N];

        if (k == 0) begin : g_leaf
            always_ff @(posedge clock4x) begin
                for (int j = 0; j < N; j++) begin
                    r_sum[j] <= w_leaf[j];
                end
            end
        end else begin : g_add
            always_ff @(posedge clock4x) begin
                for (int j = 0; j < N; j++) begin
                    r_sum[j] <= W'(g_lvl[k-1].r_sum[2*j]) + W'(g_lvl[k-1].r_sum[2*j+1]);
                end
            end
        end
    end

    logic [CNT_W-1:0] w_tree_sum;
    logic             w_tree_vld;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    assign w_tree_sum = CNT_W'(g_lvl[LVLS].r_sum[0]);
    assign w_tree_vld = r_vld[L-2];

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_tree_vld) begin
            r_cnt <= w_tree_sum;
            r_ovf <= (w_tree_sum > bus.thresh_i);
        end else begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

    logic [STAT_W-1:0] r_ovf_events;
    logic [CNT_W-1:0]  r_peak;

    // A clear wins over an update presented on the same edge; that update is lost.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_events <= '0;
            r_peak       <= '0;
        end else if (bus.clr_i) begin
            r_ovf_events <= '0;
            r_peak       <= '0;
        end else begin
            if (r_vld[L-1] && r_ovf && (r_ovf_events != '1)) begin
                r_ovf_events <= r_ovf_events + STAT_W'(1);
            end
            if (r_vld[L-1] && (r_cnt > r_peak)) begin
                r_peak <= r_cnt;
            end
        end
    end

    assign bus.cnt_o        = r_cnt;
    assign bus.overflow_o   = r_ovf;
    assign bus.valid_o      = r_vld[L-1];
    assign bus.ovf_events_o = r_ovf_events;
    assign bus.peak_o       = r_peak;

endmodule

// File: tb/tb_cluster_count_pipe.sv
// Bench for cluster_count_pipe: random and directed flag samples scored against a popcount model.
module tb_cluster_count_pipe;
    import cluster_count_pipe_pkg::*;

    localparam int NVPFS   = 1536;
    localparam int STAT_W  = 4;
    localparam int CNT_W   = 11;
    localparam int LAT     = 12;
    localparam int EVT_MAX = 15;
    localparam int QW      = 32 + 1 + CNT_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    cluster_count_pipe_if #(.NVPFS(NVPFS), .STAT_W(STAT_W)) bus ();

    cluster_count_pipe #(.NVPFS(NVPFS), .LEAF_W(6), .STAT_W(STAT_W)) dut (
        .clock4x (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [QW-1:0] exp_q[$];
    logic [QW-1:0] mon_e;
    logic          clr_edge;
    int            m_evt    = 0;
    int            m_peak   = 0;
    logic          prev_v   = 1'b0;
    int            prev_cnt = 0;
    logic          prev_ovf = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_expected(input logic [NVPFS-1:0] v);
        int c;
        logic [31:0] due;
        logic ovf;
        c   = $countones(v);
        due = 32'(cyc + LAT);
        ovf = (c > int'(bus.thresh_i));
        exp_q.push_back({due, ovf, CNT_W'(c)});
    endtask

    task automatic drive_sample(input logic [NVPFS-1:0] v, input logic vld);
        @(negedge clk);
        bus.vpfs_i  = v;
        bus.valid_i = vld;
        if (vld && rst_n) push_expected(v);
    endtask

    task automatic idle();
        drive_sample('0, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            idle();
            budget++;
        end
        idle();
        idle();
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic set_thresh(input int t);
        drain();
        @(negedge clk);
        bus.thresh_i = CNT_W'(t);
        bus.valid_i  = 1'b0;
    endtask

    task automatic clear_stats();
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.clr_i   = 1'b1;
        @(negedge clk);
        bus.clr_i   = 1'b0;
    endtask

    function automatic logic [NVPFS-1:0] rand_vec(input int density);
        logic [NVPFS-1:0] v;
        logic [31:0] w;
        for (int i = 0; i < NVPFS; i += 32) begin
            w = $urandom();
            if (density >= 1) w &= $urandom();
            if (density >= 2) w &= $urandom();
            v[i +: 32] = w;
        end
        return v;
    endfunction

    function automatic logic [NVPFS-1:0] vec_with_count(input int n);
        logic [NVPFS-1:0] v;
        v = '0;
        while ($countones(v) < n) v[$urandom_range(NVPFS-1, 0)] = 1'b1;
        return v;
    endfunction

    // ---------------- monitor / reference model ----------------
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            clr_edge = bus.clr_i;
            #1;
            if (!rst_n) begin
                m_evt  = 0;
                m_peak = 0;
                prev_v = 1'b0;
                check("valid_o_in_reset", bus.valid_o, 0);
                check("ovf_events_o_in_reset", bus.ovf_events_o, 0);
            end else begin
                if (clr_edge) begin
                    m_evt  = 0;
                    m_peak = 0;
                end else if (prev_v) begin
                    if (prev_ovf && m_evt < EVT_MAX) m_evt++;
                    if (prev_cnt > m_peak) m_peak = prev_cnt;
                end
                if (bus.valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("valid_o_unexpected", bus.valid_o, 0);
                        prev_v = 1'b0;
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("latency", cyc, mon_e[QW-1 -: 32]);
                        check("cnt_o", bus.cnt_o, mon_e[CNT_W-1:0]);
                        check("overflow_o", bus.overflow_o, mon_e[CNT_W]);
                        prev_v   = 1'b1;
                        prev_cnt = int'(mon_e[CNT_W-1:0]);
                        prev_ovf = mon_e[CNT_W];
                    end
                end else begin
                    check("idle_cnt_o", bus.cnt_o, 0);
                    check("idle_overflow_o", bus.overflow_o, 0);
                    prev_v = 1'b0;
                end
                check("ovf_events_o", bus.ovf_events_o, m_evt);
                check("peak_o", bus.peak_o, m_peak);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NVPFS-1:0] v;
        int c0;

        bus.vpfs_i   = '0;
        bus.valid_i  = 1'b0;
        bus.thresh_i = CNT_W'(8);
        bus.clr_i    = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        check("reset_cnt_o", bus.cnt_o, 0);
        check("reset_valid_o", bus.valid_o, 0);
        check("reset_overflow_o", bus.overflow_o, 0);
        check("reset_ovf_events_o", bus.ovf_events_o, 0);
        check("reset_peak_o", bus.peak_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();

        // All flags set against a low threshold: full count and one overflow event.
        set_thresh(8);
        drive_sample('1, 1'b1);
        drain();
        check("all_ones_event", bus.ovf_events_o, 1);

        // Scattered flags right at and just above the threshold.
        v = '0;
        v[0] = 1'b1; v[5] = 1'b1; v[6] = 1'b1; v[767] = 1'b1;
        v[768] = 1'b1; v[1000] = 1'b1; v[1530] = 1'b1; v[1535] = 1'b1;
        drive_sample(v, 1'b1);
        v[300] = 1'b1;
        drive_sample(v, 1'b1);
        drain();

        // Random vectors with valid toggling every cycle.
        set_thresh($urandom_range(700, 840));
        for (int i = 0; i < 40; i++) begin
            drive_sample(rand_vec($urandom_range(2, 0)), 1'(i % 2));
        end
        drain();

        // Peak tracking, then a clear landing on the edge of a further overflow.
        set_thresh(25);
        clear_stats();
        drive_sample(vec_with_count(3), 1'b1);
        drive_sample(vec_with_count(20), 1'b1);
        drive_sample(vec_with_count(7), 1'b1);
        drive_sample(vec_with_count(30), 1'b1);
        c0 = cyc;
        while (cyc < c0 + LAT) idle();
        check("peak_before_clear", bus.peak_o, 20);
        bus.clr_i = 1'b1;
        @(negedge clk);
        bus.clr_i = 1'b0;
        check("peak_after_clear", bus.peak_o, 0);
        check("events_after_clear", bus.ovf_events_o, 0);
        drain();

        // Back-to-back random samples at every cycle.
        set_thresh(768);
        for (int i = 0; i < 30; i++) begin
            drive_sample(rand_vec($urandom_range(1, 0)), 1'b1);
        end
        drain();

        // Twenty consecutive overflows drive the 4-bit event counter into saturation.
        set_thresh(8);
        for (int i = 0; i < 20; i++) drive_sample('1, 1'b1);
        drain();
        check("events_saturated", bus.ovf_events_o, EVT_MAX);

        // One-cycle reset pulse in the middle of a stream with valid_i held high.
        for (int i = 0; i < 6; i++) drive_sample(rand_vec(0), 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.vpfs_i  = rand_vec(0);
        bus.valid_i = 1'b1;
        exp_q.delete();
        #1;
        check("midreset_valid_o", bus.valid_o, 0);
        check("midreset_cnt_o", bus.cnt_o, 0);
        check("midreset_overflow_o", bus.overflow_o, 0);
        check("midreset_ovf_events_o", bus.ovf_events_o, 0);
        check("midreset_peak_o", bus.peak_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.vpfs_i = rand_vec(1);
        push_expected(bus.vpfs_i);
        for (int i = 0; i < 15; i++) drive_sample(rand_vec($urandom_range(2, 0)), 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cluster_count_pipe.md
CLUSTER_COUNT_PIPE -- requirements
Module: cluster_count_pipe

Interface
REQ-001 SHALL have parameter NVPFS, default 1536, number of valid-pattern-flag inputs; legal values are 6*2^k with k >= 1.
REQ-002 SHALL have parameter LEAF_W, default 6, flags per leaf popcount; fixed at 6.
REQ-003 SHALL have parameter STAT_W, default 16, width of the overflow event counter.
REQ-004 SHALL derive CNT_W = clog2(NVPFS+1), which is 11 at the default.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clock4x input 1 (sole clock, all logic on its rising edge), then reset_n input 1 (async assert, active low).
REQ-006 SHALL have ports: vpfs_i input NVPFS (cluster flags); valid_i input 1 (qualifies vpfs_i this cycle); thresh_i input CNT_W (overflow threshold, quasi-static); clr_i input 1 (synchronous clear of the statistics).
REQ-007 SHALL have ports: cnt_o output CNT_W (flag popcount); valid_o output 1 (cnt_o/overflow_o qualifier); overflow_o output 1 (cnt_o > thresh_i); ovf_events_o output STAT_W (saturating overflow count); peak_o output CNT_W (maximum cnt_o since last clear).

Function
REQ-008 SHALL register vpfs_i and valid_i twice (s0, s1) before counting; these registers are never merged with other copies of the same flags.
REQ-009 SHALL compute NL = NVPFS/6 leaf counts, each a 3-bit popcount of 6 adjacent flags, in one registered stage.
REQ-010 SHALL reduce the leaves with a binary adder tree of log2(NL) registered stages; each stage widens by 1 bit, capped at CNT_W; no truncation at any stage.
REQ-011 SHALL register the tree result into cnt_o one further stage, so total latency L = 4 + log2(NL): 12 cycles at NVPFS=1536, 11 at 768.
REQ-012 SHALL carry valid_i through a shift chain of L stages so valid_o is exactly aligned with cnt_o.
REQ-013 SHALL gate the data: when the tree sample is invalid, the cnt_o register loads 0 and overflow_o loads 0.
REQ-014 SHALL compute overflow_o in the same registered stage as cnt_o, as (tree sum > thresh_i) AND valid, using thresh_i as sampled at that stage.
REQ-015 SHALL increment ovf_events_o by 1 in the cycle after each cycle in which valid_o and overflow_o are both 1, saturating at 2^STAT_W-1 with no wrap.
REQ-016 SHALL load peak_o with cnt_o in the cycle after any cycle in which valid_o=1 and cnt_o > peak_o; otherwise peak_o holds.
REQ-017 SHALL zero ovf_events_o and peak_o on clr_i=1 on the next edge; clr_i takes priority over a simultaneous update, and that event is dropped.
REQ-018 SHALL leave the data pipeline unaffected by clr_i.
REQ-019 SHALL support back-to-back valid samples every cycle, with no stalls and no backpressure.
REQ-020 SHALL produce cnt_o = NVPFS when all flags are set, with no overflow of the count width.

Reset
REQ-021 SHALL, on reset_n=0, asynchronously clear all valid pipeline bits, cnt_o, overflow_o, valid_o, ovf_events_o and peak_o to 0.
REQ-022 SHALL not reset the data registers (flag and tree stages); correctness relies on the valid gating of REQ-013.
REQ-023 SHALL keep valid_o=0 for L cycles after reset deassertion, even when valid_i is held at 1.
REQ-024 SHALL discard in-flight samples when reset asserts mid-operation; none emerge after release.

Structure
REQ-025 SHALL place the clog2 function, LEAF_W, and the derivation of L and CNT_W in the shared cluster package for reuse by the cluster finder.
REQ-026 SHALL implement the leaf popcount as sub-module popcount6 (6-bit in, 3-bit out, combinational); the tree stages use generate loops, with no further sub-modules.

Verification
REQ-027 SHALL cover: NVPFS=1536, vpfs_i all 1s, valid_i=1, thresh_i=8 -> 12 cycles later cnt_o=1536, overflow_o=1, valid_o=1; next cycle ovf_events_o=1.
REQ-028 SHALL cover: exactly 8 flags set at scattered positions (bits 0, 5, 6, 767, 768, 1000, 1530, 1535), thresh_i=8 -> cnt_o=8, overflow_o=0; with 9 flags set -> cnt_o=9, overflow_o=1.
REQ-029 SHALL cover: random flag vectors, valid_i toggling every cycle, compared against a reference popcount -> each sample matches at latency 12; invalid slots give cnt_o=0 and valid_o=0.
REQ-030 SHALL cover: samples with counts 3, 20, 7 followed by clr_i asserted coincident with a further overflow at count 30 -> peak_o=20, then 0 after the clear edge; ovf_events_o=0.
REQ-031 SHALL cover: ovf_events_o preloaded near saturation (STAT_W=4) with 20 consecutive overflows -> holds at 15.
REQ-032 SHALL cover: reset_n pulsed low for 1 cycle mid-stream -> all outputs 0 immediately; valid_o stays 0 for 12 cycles after release.
